// File: rtl/sa_scan_pkg.sv
// Shared types and defaults for the stuck-at fault sweep block.
package sa_scan_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StSample = 2'd2,
    StFinish = 2'd3
  } scan_state_e;

  localparam int unsigned DefNIn          = 3;
  localparam int unsigned DefSettleCycles = 2;

endpackage

// File: rtl/sa_result_acc.sv
// Detect mask / count / first-detecting-vector accumulator.
module sa_result_acc
  import sa_scan_pkg::*;
#(
  parameter int unsigned N_IN = DefNIn
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 sample_en,
  input  logic                 miss,
  input  logic [N_IN-1:0]      vec,
  output logic [2**N_IN-1:0]   detect_mask,
  output logic [N_IN:0]        detect_count,
  output logic [N_IN-1:0]      first_vec,
  output logic                 first_valid
);

  localparam int unsigned NVec = 2**N_IN;

  logic [NVec-1:0] mask_q, mask_d;
  logic [N_IN:0]   count_q, count_d;
  logic [N_IN-1:0] first_q, first_d;
  logic            fvalid_q, fvalid_d;

  // Clear on sweep start; otherwise fold in a detecting sample.
  always_comb begin
    mask_d   = mask_q;
    count_d  = count_q;
    first_d  = first_q;
    fvalid_d = fvalid_q;
    if (clr) begin
      mask_d   = '0;
      count_d  = '0;
      first_d  = '0;
      fvalid_d = 1'b0;
    end else if (sample_en && miss) begin
      mask_d[vec] = 1'b1;
      count_d     = count_q + {{N_IN{1'b0}}, 1'b1};
      if (!fvalid_q) begin
        first_d  = vec;
        fvalid_d = 1'b1;
      end
    end
  end

  // Result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q   <= '0;
      count_q  <= '0;
      first_q  <= '0;
      fvalid_q <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      count_q  <= count_d;
      first_q  <= first_d;
      fvalid_q <= fvalid_d;
    end
  end

  assign detect_mask  = mask_q;
  assign detect_count = count_q;
  assign first_vec    = first_q;
  assign first_valid  = fvalid_q;

endmodule

// File: rtl/sa_fault_scan.sv
// Stuck-at test sweeper: drives all input vectors in order, samples F0/F1 after a settle
// interval and accumulates which vectors expose the fault.
module sa_fault_scan
  import sa_scan_pkg::*;
#(
  parameter int unsigned N_IN          = DefNIn,
  parameter int unsigned SETTLE_CYCLES = DefSettleCycles
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 f_good,
  input  logic                 f_fault,
  output logic [N_IN-1:0]      vec_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   detect_mask,
  output logic [N_IN:0]        detect_count,
  output logic [N_IN-1:0]      first_vec,
  output logic                 first_valid
);

  localparam logic [N_IN-1:0] VecMax     = '1;
  localparam logic [3:0]      SettleLast =
      (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

  scan_state_e     state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q;
  logic            clr, sample_en;

  // Next-state, vector stepping and settle counting.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    clr       = 1'b0;
    sample_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          vec_d = '0;
          cnt_d = '0;
          clr   = 1'b1;
          if (SETTLE_CYCLES > 0) state_d = StSettle;
          else                   state_d = StSample;
        end
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StSample: begin
        sample_en = 1'b1;
        // Terminal compare keeps vec_out from wrapping past all-ones.
        if (vec_q == VecMax) begin
          state_d = StFinish;
        end else begin
          vec_d = vec_q + {{(N_IN-1){1'b0}}, 1'b1};
          if (SETTLE_CYCLES > 0) state_d = StSettle;
          else                   state_d = StSample;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    busy_d = (state_d == StSettle) || (state_d == StSample);
  end

  // FSM, vector and flag registers; done pulses for the cycle after FINISH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= (state_q == StFinish);
    end
  end

  sa_result_acc #(
    .N_IN(N_IN)
  ) u_acc (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .sample_en    (sample_en),
    .miss         (f_good ^ f_fault),
    .vec          (vec_q),
    .detect_mask  (detect_mask),
    .detect_count (detect_count),
    .first_vec    (first_vec),
    .first_valid  (first_valid)
  );

  assign vec_out = vec_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sa_fault_scan.sv
module tb_sa_fault_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start2, start0;
  int         mode;
  int         errors = 0;
  int         checks = 0;

  logic       f_good2, f_fault2, f_good0, f_fault0;
  logic [2:0] vec2, vec0;
  logic       busy2, done2, busy0, done0;
  logic [7:0] mask2, mask0;
  logic [3:0] count2, count0;
  logic [2:0] fv2, fv0;
  logic       fvalid2, fvalid0;

  always #5 clk = ~clk;

  // Circuit-under-test model: A=vec[2], B=vec[1], C=vec[0].
  function automatic logic cut_good(input logic [2:0] v);
    return v[2] & v[1];
  endfunction

  function automatic logic cut_fault(input int m, input logic [2:0] v);
    case (m)
      1:       return ~(v[2] & v[1]);
      2:       return v[2];
      default: return v[2] & v[1];
    endcase
  endfunction

  assign f_good2  = cut_good(vec2);
  assign f_fault2 = cut_fault(mode, vec2);
  assign f_good0  = cut_good(vec0);
  assign f_fault0 = cut_fault(mode, vec0);

  sa_fault_scan #(
    .N_IN          (3),
    .SETTLE_CYCLES (2)
  ) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start2),
    .f_good       (f_good2),
    .f_fault      (f_fault2),
    .vec_out      (vec2),
    .busy         (busy2),
    .done         (done2),
    .detect_mask  (mask2),
    .detect_count (count2),
    .first_vec    (fv2),
    .first_valid  (fvalid2)
  );

  sa_fault_scan #(
    .N_IN          (3),
    .SETTLE_CYCLES (0)
  ) dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start0),
    .f_good       (f_good0),
    .f_fault      (f_fault0),
    .vec_out      (vec0),
    .busy         (busy0),
    .done         (done0),
    .detect_mask  (mask0),
    .detect_count (count0),
    .first_vec    (fv0),
    .first_valid  (fvalid0)
  );

  // Pulse start for one edge (edge k); returns at the negedge after edge k.
  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start0 = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
  endtask

  // Returns the edge index (relative to k) after which done is seen, or -1.
  task automatic wait_done(input bit sel, input int limit, output int e);
    e = -1;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk);
      @(negedge clk);
      if ((sel ? done0 : done2) === 1'b1) begin
        e = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start2 = 1'b0;
    start0 = 1'b0;
    mode   = 0;
    #3;
    checks++;
    if ({vec2, busy2, done2, mask2, count2, fv2, fvalid2} !== 21'd0) begin
      errors++;
      $display("FAIL reset_dut2: got %h want 0",
               {vec2, busy2, done2, mask2, count2, fv2, fvalid2});
    end
    checks++;
    if ({vec0, busy0, done0, mask0, count0, fv0, fvalid0} !== 21'd0) begin
      errors++;
      $display("FAIL reset_dut0: got %h want 0",
               {vec0, busy0, done0, mask0, count0, fv0, fvalid0});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy2, done2} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: busy/done got %b want 00", {busy2, done2});
    end
  endtask

  task automatic test_no_fault();
    int e;
    mode = 0;
    pulse_start(1'b0);
    checks++;
    if ({busy2, vec2} !== 4'b1_000) begin
      errors++;
      $display("FAIL nofault_start: busy,vec got %b want 1000", {busy2, vec2});
    end
    wait_done(1'b0, 40, e);
    checks++;
    if (e !== 25) begin
      errors++;
      $display("FAIL nofault_done_edge: got %0d want 25", e);
    end
    checks++;
    if ({mask2, count2, fvalid2, busy2} !== 14'd0) begin
      errors++;
      $display("FAIL nofault_results: mask %h count %0d fvalid %b busy %b want 0 0 0 0",
               mask2, count2, fvalid2, busy2);
    end
    @(negedge clk);
    checks++;
    if (done2 !== 1'b0) begin
      errors++;
      $display("FAIL nofault_done_width: done got %b want 0", done2);
    end
  endtask

  task automatic test_always_differs();
    int e;
    mode = 1;
    pulse_start(1'b0);
    wait_done(1'b0, 40, e);
    checks++;
    if (e !== 25) begin
      errors++;
      $display("FAIL differs_done_edge: got %0d want 25", e);
    end
    checks++;
    if ({mask2, count2, fv2, fvalid2} !== {8'hFF, 4'd8, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL differs_results: mask %h count %0d fv %0d fvalid %b want ff 8 0 1",
               mask2, count2, fv2, fvalid2);
    end
  endtask

  task automatic test_sa1_schedule();
    logic [2:0] exp_vec;
    logic [7:0] exp_mask;
    mode = 2;
    pulse_start(1'b0);
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk);
      @(negedge clk);
      exp_vec  = (e / 3 > 7) ? 3'd7 : 3'(e / 3);
      exp_mask = 8'h00;
      if (e >= 15) exp_mask[4] = 1'b1;
      if (e >= 18) exp_mask[5] = 1'b1;
      checks++;
      if ({vec2, mask2, done2} !== {exp_vec, exp_mask, (e == 25)}) begin
        errors++;
        $display("FAIL sa1_edge%0d: vec %0d mask %h done %b want %0d %h %b",
                 e, vec2, mask2, done2, exp_vec, exp_mask, (e == 25));
      end
    end
    checks++;
    if ({count2, fv2, fvalid2} !== {4'd2, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL sa1_results: count %0d fv %0d fvalid %b want 2 4 1",
               count2, fv2, fvalid2);
    end
  endtask

  task automatic test_restart_busy();
    mode = 2;
    pulse_start(1'b0);
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk);
      @(negedge clk);
      start2 = (e == 10);
      checks++;
      if (done2 !== (e == 25)) begin
        errors++;
        $display("FAIL restart_done_edge%0d: got %b want %b", e, done2, (e == 25));
      end
    end
    start2 = 1'b0;
    checks++;
    if ({mask2, count2, fv2} !== {8'h30, 4'd2, 3'd4}) begin
      errors++;
      $display("FAIL restart_results: mask %h count %0d fv %0d want 30 2 4",
               mask2, count2, fv2);
    end
  endtask

  task automatic test_start_held();
    int e2;
    mode = 1;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int e = 1; e <= 26; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 25) begin
        checks++;
        if ({done2, mask2} !== {1'b1, 8'hFF}) begin
          errors++;
          $display("FAIL held_first_done: done %b mask %h want 1 ff", done2, mask2);
        end
        mode = 0;
      end
      if (e == 26) begin
        checks++;
        if ({mask2, count2, fvalid2, busy2, vec2, done2} !== {8'h00, 4'd0, 1'b0, 1'b1, 3'd0, 1'b0})
        begin
          errors++;
          $display("FAIL held_clear: mask %h count %0d fvalid %b busy %b vec %0d done %b",
                   mask2, count2, fvalid2, busy2, vec2, done2);
        end
      end
    end
    start2 = 1'b0;
    wait_done(1'b0, 40, e2);
    checks++;
    if ({e2, mask2} !== {32'sd25, 8'h00}) begin
      errors++;
      $display("FAIL held_second: done edge %0d mask %h want 25 00", e2, mask2);
    end
  endtask

  task automatic test_reset_mid();
    int found, seen, e;
    mode = 2;
    pulse_start(1'b0);
    found = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (vec2 === 3'd5) begin
        found = c;
        break;
      end
    end
    checks++;
    if ({found, mask2} !== {32'sd15, 8'h10}) begin
      errors++;
      $display("FAIL midreset_reach5: edge %0d mask %h want 15 10", found, mask2);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({vec2, busy2, done2, mask2, count2, fv2, fvalid2} !== 21'd0) begin
      errors++;
      $display("FAIL midreset_clear: got %h want 0",
               {vec2, busy2, done2, mask2, count2, fv2, fvalid2});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done2 !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midreset_no_done: done cycles %0d want 0", seen);
    end
    pulse_start(1'b0);
    wait_done(1'b0, 40, e);
    checks++;
    if ({e, mask2, count2, fv2, fvalid2} !== {32'sd25, 8'h30, 4'd2, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL midreset_rerun: edge %0d mask %h count %0d fv %0d fvalid %b",
               e, mask2, count2, fv2, fvalid2);
    end
  endtask

  task automatic test_zero_settle();
    logic [2:0] exp_vec;
    logic [7:0] exp_mask;
    mode = 2;
    pulse_start(1'b1);
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk);
      @(negedge clk);
      exp_vec  = (e > 7) ? 3'd7 : 3'(e);
      exp_mask = 8'h00;
      if (e >= 5) exp_mask[4] = 1'b1;
      if (e >= 6) exp_mask[5] = 1'b1;
      checks++;
      if ({vec0, mask0, done0} !== {exp_vec, exp_mask, (e == 9)}) begin
        errors++;
        $display("FAIL zero_edge%0d: vec %0d mask %h done %b want %0d %h %b",
                 e, vec0, mask0, done0, exp_vec, exp_mask, (e == 9));
      end
    end
    checks++;
    if ({count0, fv0, fvalid0} !== {4'd2, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL zero_results: count %0d fv %0d fvalid %b want 2 4 1",
               count0, fv0, fvalid0);
    end
  endtask

  initial begin
    test_reset();
    test_no_fault();
    test_always_differs();
    test_sa1_schedule();
    test_restart_busy();
    test_start_held();
    test_reset_mid();
    test_zero_settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
